// File: rtl/regfile_32x64.sv
// -----------------------------------------------------------------------------
// regfile_32x64
//   Architectural register file for the 5-stage ARM pipeline.
//   - 31 writable 64-bit registers X0..X30. X31 (XZR) has no storage and
//     always reads as zero.
//   - Two independent combinational read ports feed the ID stage. Each port
//     is a 32:1 select tree of 2:1 cells addressed bit by bit.
//   - One synchronous write port is driven from WB. Writes to X31 are dropped.
//
// Ports
//   clk            pipeline clock; state updates on the rising edge
//   reset_n        asynchronous active-low reset; clears X0..X30
//   RegWrite       write enable
//   WriteRegister  destination index (5 bits)
//   WriteData      write data (WIDTH bits)
//   ReadRegister1  read port 1 index (Rn)
//   ReadRegister2  read port 2 index (Rm/Rt)
//   ReadData1      contents of ReadRegister1
//   ReadData2      contents of ReadRegister2
//
// Build option
//   REGFILE_BYPASS_EN  When this macro is defined, a write-through bypass is
//                      added. A read that matches the index being written in
//                      the same cycle returns WriteData combinationally.
//                      When it is undefined, reads return only stored state.
// -----------------------------------------------------------------------------
module regfile_32x64 #(
    parameter int WIDTH = 64,
    parameter int NREG  = 32   // fixed at 32 (5-bit indices)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam int NSTORE = NREG - 1;   // XZR carries no storage

    logic [WIDTH-1:0] r_regs [0:NSTORE-1];
    logic [NSTORE-1:0] w_we;

    // One-hot write decode. Decode output 31 is never generated, so a write
    // to XZR enables nothing.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < NSTORE; i++) begin
            w_we[i] = RegWrite && (WriteRegister == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSTORE; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSTORE; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    // Read select trees, stored in heap order. Node n has children 2n and
    // 2n+1. Leaves 32..63 hold registers 0..31. A node at depth d is steered
    // by address bit 4-d, so the root uses the MSB and the leaf parents use
    // the LSB. The tree has five levels of 2:1 cells.
    logic [WIDTH-1:0] w_t1 [1:63];
    logic [WIDTH-1:0] w_t2 [1:63];

    for (genvar i = 0; i < 32; i++) begin : g_leaf
        if (i < NSTORE) begin : g_reg
            assign w_t1[32+i] = r_regs[i];
            assign w_t2[32+i] = r_regs[i];
        end else begin : g_zero
            assign w_t1[32+i] = '0;
            assign w_t2[32+i] = '0;
        end
    end

    for (genvar n = 1; n < 32; n++) begin : g_node
        localparam int D = $clog2(n + 1) - 1;   // depth of node n
        assign w_t1[n] = ReadRegister1[4-D] ? w_t1[2*n+1] : w_t1[2*n];
        assign w_t2[n] = ReadRegister2[4-D] ? w_t2[2*n+1] : w_t2[2*n];
    end

`ifdef REGFILE_BYPASS_EN
    // A match can only occur when WriteRegister != 31. An XZR read therefore
    // never picks up WriteData.
    logic w_byp_ok;
    assign w_byp_ok  = RegWrite && (WriteRegister != 5'd31);
    assign ReadData1 = (w_byp_ok && (ReadRegister1 == WriteRegister)) ? WriteData : w_t1[1];
    assign ReadData2 = (w_byp_ok && (ReadRegister2 == WriteRegister)) ? WriteData : w_t2[1];
`else
    assign ReadData1 = w_t1[1];
    assign ReadData2 = w_t2[1];
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
module tb_regfile_32x64;

  localparam int W = 64;
  localparam logic [W-1:0] STEP = 64'h0101_0101_0101_0101;

  logic         clk;
  logic         reset_n;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [W-1:0] WriteData;
  logic [4:0]   ReadRegister1;
  logic [4:0]   ReadRegister2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_32x64 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // driver tasks
  // Present a write on the falling edge, let the rising edge take it, then drop the enable.
  task automatic write_reg(input logic [4:0] idx, input logic [W-1:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite      = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [W-1:0] e1, input logic [W-1:0] e2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
    check({tag, "_rd1"}, ReadData1, e1);
    check({tag, "_rd2"}, ReadData2, e2);
  endtask

  function automatic logic [W-1:0] pattern(input int i);
    logic [W-1:0] m;
    m = W'(i + 1);
    return STEP * m;
  endfunction

  initial begin
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    reset_n       = 1'b0;

    // reset state
    #12;
    read_check("rst_x0_x31", 5'd0, 5'd31, 0, 0);
    read_check("rst_x30_x15", 5'd30, 5'd15, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // mid-cycle asynchronous reset
    write_reg(5'd5, 64'hDEAD_BEEF);
    read_check("x5_written", 5'd5, 5'd5, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_x5", ReadData1, 0);
    // write attempted while reset is held low is lost
    RegWrite = 1'b1; WriteRegister = 5'd6; WriteData = 64'h55;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    read_check("rst_blocks_wr", 5'd6, 5'd5, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // write and read back every register
    for (int i = 0; i < 31; i++) write_reg(5'(i), pattern(i));
    for (int i = 0; i < 31; i++) read_check($sformatf("all_x%0d", i), 5'(i), 5'(30 - i), pattern(i), pattern(30 - i));
    read_check("all_x31", 5'd31, 5'd31, 0, 0);

    // a write to XZR is discarded
    write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    read_check("xzr_write", 5'd31, 5'd31, 0, 0);
    for (int i = 0; i < 31; i++) read_check($sformatf("xzr_keep_x%0d", i), 5'(i), 5'(i), pattern(i), pattern(i));

    // write enable low
    @(negedge clk);
    RegWrite = 1'b0; WriteRegister = 5'd7; WriteData = 64'h1234;
    @(posedge clk);
    #1;
    read_check("we_low_x7", 5'd7, 5'd7, 64'h0808_0808_0808_0808, 64'h0808_0808_0808_0808);

    // same-cycle read and write of X3
    write_reg(5'd3, 64'h11);
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h22;
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd31;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rw_x3_before", ReadData1, 64'h22);
`else
    check("rw_x3_before", ReadData1, 64'h11);
`endif
    check("rw_x31_no_byp", ReadData2, 0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    check("rw_x3_after", ReadData1, 64'h22);

    // dual port
    write_reg(5'd10, 64'hCAFE);
    read_check("dual_same", 5'd10, 5'd10, 64'hCAFE, 64'hCAFE);
    read_check("dual_x31", 5'd10, 5'd31, 64'hCAFE, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
